// File: rtl/matrix_8x8_rx_if.sv
// Serial link and display bus of the 8x8 matrix receiver.
// The transmitter side drives sclk/din/cs_n; the receiver drives the matrix and commit strobes.
interface matrix_8x8_rx_if;
    logic       sclk;
    logic       din;
    logic       cs_n;
    logic [7:0] row_n;
    logic [7:0] col;
    logic [4:0] bcount;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;

    modport master (
        output sclk, din, cs_n,
        input  row_n, col, bcount, wr_stb, wr_addr, wr_data, frame_err
    );

    modport slave (
        input  sclk, din, cs_n,
        output row_n, col, bcount, wr_stb, wr_addr, wr_data, frame_err
    );
endinterface

// File: rtl/matrix_8x8_rx.sv
// MAX7219-style receiver: decodes 16-bit serial frames into a row/control register
// file and multiplexes the rows onto an 8x8 LED matrix with PWM brightness.
module matrix_8x8_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PWM_DIV     = 4
) (
    input logic            clk,
    input logic            rst,
    matrix_8x8_rx_if.slave bus
);
    localparam int              SUB_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PWM_DIV - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, din_sync_q, cs_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, din_s, cs_s, sclk_rise_s, cs_rise_s, cs_fall_s;

    logic [15:0]     sr_q, sr_d;
    logic [4:0]      bcount_q, bcount_d;
    logic            active_q, active_d;
    logic [7:0][7:0] rows_q, rows_d;
    logic [3:0]      intensity_q, intensity_d;
    logic [2:0]      scan_limit_q, scan_limit_d;
    logic            shutdown_q, shutdown_d;
    logic            test_q, test_d;
    logic            commit_s, err_s;
    logic            wr_stb_q, frame_err_q;
    logic [3:0]      wr_addr_q;
    logic [7:0]      wr_data_q;

    logic [SUB_W-1:0] sub_q, sub_d;
    logic [3:0]       pwm_q, pwm_d;
    logic [2:0]       row_q, row_d, lim_s;
    logic [7:0]       row_onehot_s;
    logic [7:0]       row_n_q, row_n_d, col_q, col_d;

    // Synchroniser chain and edge-history flops; deliberately not reset so a cs_n
    // held low across reset is never mistaken for a fresh frame start.
    always_ff @(posedge clk) begin
        sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], bus.din};
        cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
        sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign din_s       = din_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign cs_rise_s   = cs_s & ~cs_prev_q;
    assign cs_fall_s   = ~cs_s & cs_prev_q;

    // Frame reception and commit decode; a shift coincident with cs_n rising lands first.
    always_comb begin
        sr_d         = sr_q;
        bcount_d     = bcount_q;
        active_d     = active_q;
        rows_d       = rows_q;
        intensity_d  = intensity_q;
        scan_limit_d = scan_limit_q;
        shutdown_d   = shutdown_q;
        test_d       = test_q;
        commit_s     = 1'b0;
        err_s        = 1'b0;
        if (cs_fall_s) begin
            bcount_d = 5'd0;
            active_d = 1'b1;
        end else begin
            if (sclk_rise_s && active_q) begin
                sr_d     = {sr_q[14:0], din_s};
                bcount_d = (bcount_q == 5'd16) ? 5'd16 : bcount_q + 5'd1;
            end else begin
                sr_d = sr_q;
            end
            if (cs_rise_s && active_q) begin
                active_d = 1'b0;
                commit_s = (bcount_d == 5'd16);
                err_s    = (bcount_d != 5'd16);
            end else begin
                active_d = active_q;
            end
        end
        if (commit_s) begin
            case (sr_d[11:8])
                4'h1, 4'h2, 4'h3, 4'h4,
                4'h5, 4'h6, 4'h7, 4'h8: rows_d[3'(sr_d[11:8] - 4'd1)] = sr_d[7:0];
                4'hA:    intensity_d  = sr_d[3:0];
                4'hB:    scan_limit_d = sr_d[2:0];
                4'hC:    shutdown_d   = ~sr_d[0];
                4'hF:    test_d       = sr_d[0];
                default: rows_d       = rows_q;
            endcase
        end else begin
            rows_d = rows_q;
        end
    end

    // Scan counters: sub-slot -> PWM step -> row; test mode sweeps all eight rows.
    always_comb begin
        lim_s = test_q ? 3'd7 : scan_limit_q;
        sub_d = sub_q;
        pwm_d = pwm_q;
        row_d = row_q;
        if (sub_q == SUB_LAST) begin
            sub_d = '0;
            pwm_d = pwm_q + 4'd1;
        end else begin
            sub_d = sub_q + SUB_W'(1);
        end
        if (row_q > lim_s) begin
            row_d = 3'd0;
        end else if ((sub_q == SUB_LAST) && (pwm_q == 4'd15)) begin
            row_d = (row_q == lim_s) ? 3'd0 : row_q + 3'd1;
        end else begin
            row_d = row_q;
        end
    end

    // Matrix drive derived from the current counters, registered one clock later.
    always_comb begin
        row_onehot_s = 8'd1 << row_q;
        row_n_d      = 8'hFF;
        col_d        = 8'h00;
        if (test_q) begin
            row_n_d = ~row_onehot_s;
            col_d   = 8'hFF;
        end else if (shutdown_q) begin
            row_n_d = 8'hFF;
            col_d   = 8'h00;
        end else begin
            row_n_d = ~row_onehot_s;
            col_d   = (pwm_q <= intensity_q) ? rows_q[row_q] : 8'h00;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q         <= 16'h0000;
            bcount_q     <= 5'd0;
            active_q     <= 1'b0;
            rows_q       <= '0;
            intensity_q  <= 4'd0;
            scan_limit_q <= 3'd0;
            shutdown_q   <= 1'b1;
            test_q       <= 1'b0;
            wr_stb_q     <= 1'b0;
            wr_addr_q    <= 4'd0;
            wr_data_q    <= 8'h00;
            frame_err_q  <= 1'b0;
            sub_q        <= '0;
            pwm_q        <= 4'd0;
            row_q        <= 3'd0;
            row_n_q      <= 8'hFF;
            col_q        <= 8'h00;
        end else begin
            sr_q         <= sr_d;
            bcount_q     <= bcount_d;
            active_q     <= active_d;
            rows_q       <= rows_d;
            intensity_q  <= intensity_d;
            scan_limit_q <= scan_limit_d;
            shutdown_q   <= shutdown_d;
            test_q       <= test_d;
            wr_stb_q     <= commit_s;
            frame_err_q  <= err_s;
            if (commit_s) begin
                wr_addr_q <= sr_d[11:8];
                wr_data_q <= sr_d[7:0];
            end
            sub_q        <= sub_d;
            pwm_q        <= pwm_d;
            row_q        <= row_d;
            row_n_q      <= row_n_d;
            col_q        <= col_d;
        end
    end

    assign bus.row_n     = row_n_q;
    assign bus.col       = col_q;
    assign bus.bcount    = bcount_q;
    assign bus.wr_stb    = wr_stb_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_matrix_8x8_rx.sv
// Directed bench for matrix_8x8_rx: a frame table plus hand-written corner sequences.
module tb_matrix_8x8_rx;
    logic clk;
    logic rst;
    matrix_8x8_rx_if bus ();

    matrix_8x8_rx #(.SYNC_STAGES(2), .PWM_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] frame;
        logic [3:0]  addr;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   stb_cnt = 0;
    int   err_cnt = 0;
    logic [3:0] last_addr;
    logic [7:0] last_data;
    int   hits[8];
    int   ff_cnt, zero_cnt, bad_cnt, diag_cnt;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.wr_stb === 1'b1) begin
            stb_cnt++;
            last_addr = bus.wr_addr;
            last_data = bus.wr_data;
        end
        if (bus.frame_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.din = v[i];
            clks(4);
            bus.sclk = 1'b1;
            clks(4);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] f);
        bus.cs_n = 1'b0;
        clks(4);
        shift_bits({16'h0000, f}, 16);
        clks(4);
        bus.cs_n = 1'b1;
        clks(10);
    endtask

    task automatic sample(input int n);
        logic [7:0] m;
        for (int r = 0; r < 8; r++) hits[r] = 0;
        ff_cnt = 0; zero_cnt = 0; bad_cnt = 0; diag_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int r = 0; r < 8; r++) begin
                m = 8'd1 << r;
                if (bus.row_n == ~m) hits[r]++;
            end
            if ($countones(~bus.row_n) != 1) bad_cnt++;
            if (bus.col == 8'hFF) ff_cnt++;
            if (bus.col == 8'h00) zero_cnt++;
            if (bus.col == ~bus.row_n) diag_cnt++;
        end
    endtask

    initial begin
        int s0, e0;
        rst = 1'b1;
        bus.sclk = 1'b0;
        bus.din  = 1'b0;
        bus.cs_n = 1'b1;
        clks(6);
        rst = 1'b0;
        clks(1);

        chk("rst_row_n", bus.row_n, 8'hFF);
        chk("rst_col", bus.col, 8'h00);
        chk("rst_bcount", bus.bcount, 5'd0);
        chk("rst_wr_stb", bus.wr_stb, 1'b0);
        chk("rst_wr_addr", bus.wr_addr, 4'h0);
        chk("rst_wr_data", bus.wr_data, 8'h00);
        chk("rst_frame_err", bus.frame_err, 1'b0);

        vecs.push_back('{16'h0C01, 4'hC, 8'h01});
        vecs.push_back('{16'h0B07, 4'hB, 8'h07});
        vecs.push_back('{16'h0A0F, 4'hA, 8'h0F});
        vecs.push_back('{16'h0912, 4'h9, 8'h12});
        vecs.push_back('{16'h0E34, 4'hE, 8'h34});
        vecs.push_back('{16'h0101, 4'h1, 8'h01});
        vecs.push_back('{16'h0202, 4'h2, 8'h02});
        vecs.push_back('{16'h0304, 4'h3, 8'h04});
        vecs.push_back('{16'h0408, 4'h4, 8'h08});
        vecs.push_back('{16'h0510, 4'h5, 8'h10});
        vecs.push_back('{16'h0620, 4'h6, 8'h20});
        vecs.push_back('{16'h0740, 4'h7, 8'h40});
        vecs.push_back('{16'h0880, 4'h8, 8'h80});

        foreach (vecs[i]) begin
            s0 = stb_cnt;
            send_frame(vecs[i].frame);
            chk($sformatf("vec%0d_stb", i), stb_cnt - s0, 1);
            chk($sformatf("vec%0d_addr", i), last_addr, vecs[i].addr);
            chk($sformatf("vec%0d_data", i), last_data, vecs[i].data);
            chk($sformatf("vec%0d_bcount", i), bus.bcount, 5'd16);
        end

        // Diagonal pattern, 8 rows x 64 cycles, full duty.
        sample(512);
        for (int r = 0; r < 8; r++) chk($sformatf("scan_row%0d_cycles", r), hits[r], 64);
        chk("scan_onehot", bad_cnt, 0);
        chk("scan_col_diag", diag_cnt, 512);

        // Intensity 3 on a single full row.
        send_frame(16'h0A03);
        send_frame(16'h01FF);
        send_frame(16'h0B00);
        clks(4);
        sample(512);
        chk("int3_ff_cycles", ff_cnt, 128);
        chk("int3_zero_cycles", zero_cnt, 384);
        chk("int3_row0", hits[0], 512);

        // Short 12-bit frame; a false commit would decode as intensity 0x0F.
        s0 = stb_cnt; e0 = err_cnt;
        bus.cs_n = 1'b0;
        clks(4);
        shift_bits(32'h0000_0A0F, 12);
        clks(4);
        chk("short_bcount_pre", bus.bcount, 5'd12);
        bus.cs_n = 1'b1;
        clks(10);
        chk("short_err", err_cnt - e0, 1);
        chk("short_stb", stb_cnt - s0, 0);
        chk("short_bcount_post", bus.bcount, 5'd12);
        sample(512);
        chk("short_regs_kept", ff_cnt, 128);

        // 20-bit frame, last 16 bits count.
        s0 = stb_cnt; e0 = err_cnt;
        bus.cs_n = 1'b0;
        clks(4);
        shift_bits(32'h000F_0355, 20);
        clks(4);
        chk("long_bcount", bus.bcount, 5'd16);
        bus.cs_n = 1'b1;
        clks(10);
        chk("long_stb", stb_cnt - s0, 1);
        chk("long_addr", last_addr, 4'h3);
        chk("long_data", last_data, 8'h55);
        chk("long_err", err_cnt - e0, 0);

        // Shutdown, then test mode overrides it.
        send_frame(16'h0B07);
        send_frame(16'h0C00);
        clks(4);
        chk("shdn_row_n", bus.row_n, 8'hFF);
        chk("shdn_col", bus.col, 8'h00);
        send_frame(16'h0F01);
        sample(512);
        chk("test_col_ff", ff_cnt, 512);
        chk("test_onehot", bad_cnt, 0);
        chk("test_row7", hits[7], 64);
        send_frame(16'h0F00);
        clks(4);
        chk("untest_row_n", bus.row_n, 8'hFF);
        chk("untest_col", bus.col, 8'h00);

        // Last data bit's sclk rise coincides with cs_n rise.
        s0 = stb_cnt;
        bus.cs_n = 1'b0;
        clks(4);
        shift_bits(32'h0000_00A1, 15);
        bus.din = 1'b0;
        clks(4);
        bus.sclk = 1'b1;
        bus.cs_n = 1'b1;
        clks(4);
        bus.sclk = 1'b0;
        clks(8);
        chk("coinc_stb", stb_cnt - s0, 1);
        chk("coinc_addr", last_addr, 4'h1);
        chk("coinc_data", last_data, 8'h42);

        // Reset mid-frame with cs_n held low: remainder is ignored.
        s0 = stb_cnt; e0 = err_cnt;
        bus.cs_n = 1'b0;
        clks(4);
        shift_bits(32'h0000_0001, 8);
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        clks(2);
        chk("rstmid_bcount", bus.bcount, 5'd0);
        chk("rstmid_row_n", bus.row_n, 8'hFF);
        shift_bits(32'h0000_00AA, 8);
        clks(4);
        bus.cs_n = 1'b1;
        clks(10);
        chk("rstmid_stb", stb_cnt - s0, 0);
        chk("rstmid_err", err_cnt - e0, 0);
        chk("rstmid_bcount_end", bus.bcount, 5'd0);

        // Reset mid-frame, then a fresh cs_n fall: the 8-bit remainder is a short frame.
        s0 = stb_cnt; e0 = err_cnt;
        bus.cs_n = 1'b0;
        clks(4);
        shift_bits(32'h0000_0001, 8);
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        bus.cs_n = 1'b1;
        clks(6);
        bus.cs_n = 1'b0;
        clks(4);
        shift_bits(32'h0000_00AA, 8);
        clks(4);
        bus.cs_n = 1'b1;
        clks(10);
        chk("refall_err", err_cnt - e0, 1);
        chk("refall_stb", stb_cnt - s0, 0);
        chk("refall_bcount", bus.bcount, 5'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_8x8_rx.md
Name: matrix_8x8_rx

Overview:
- Receiving end of the matrix serial link: a MAX7219-style display controller that accepts the 16-bit frames (cs_n, serial clock, data) produced by the matrix transmitter.
- Decodes each frame into a register file of 8 row bytes plus control registers.
- Multiplexes the rows onto an 8x8 LED matrix with per-row PWM brightness.
- Used as a behavioural-accurate bench partner for the transmitter and as synthesizable hardware for boards with a bare matrix.

Parameters:
SYNC_STAGES, 2, flop stages synchronising sclk/din/cs_n into clk domain (min 2)
PWM_DIV, 4, clk cycles per PWM sub-slot; one row slot = 16*PWM_DIV clk cycles

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
sclk  input  1  serial clock from transmitter, asynchronous, max freq clk/4
din  input  1  serial data, MSB first, valid at sclk rising edge
cs_n  input  1  active-low frame select; rising edge latches frame
row_n  output  8  active-low row enables, one-hot-low or all high
col  output  8  column drive, active high
bcount  output  5  bits shifted in current frame, saturates at 16
wr_stb  output  1  one-cycle pulse when a frame is committed
wr_addr  output  4  address of committed frame, valid with wr_stb
wr_data  output  8  data of committed frame, valid with wr_stb
frame_err  output  1  one-cycle pulse when cs_n rises with bcount < 16

Behaviour:
- Reset values: row_n=8'hFF, col=0, bcount=0, wr_stb=0, wr_addr=0, wr_data=0, frame_err=0, shift reg=0, rows[0..7]=0, intensity=0, scan_limit=0, shutdown=1, test=0, scan counters=0.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised signals.
- sclk rising while cs_n low: shift din into 16-bit shift reg LSB, shift left. bcount increments, saturating at 16. Beyond 16 bits the shift reg keeps the last 16 bits.
- sclk edges while cs_n high are ignored.
- cs_n falling: bcount cleared to 0.
- cs_n rising with bcount==16: commit frame. Fields are addr=sr[11:8] and data=sr[7:0]; sr[15:12] is ignored. wr_stb pulses 1 cycle, 1 clk after the synchronised edge. bcount holds its value until the next cs_n fall.
- cs_n rising with bcount<16: no register change; frame_err pulses 1 cycle.
- Commit decode:
  - addr 1-8: rows[addr-1]=data
  - 0x0: no-op
  - 0x9: decode mode, accepted and ignored
  - 0xA: intensity=data[3:0]
  - 0xB: scan_limit=data[2:0]
  - 0xC: shutdown=~data[0]
  - 0xF: test=data[0]
  - others: ignored
  - wr_stb fires for every committed frame, including ignored addresses.
- Scan:
  - sub-slot counter counts 0..PWM_DIV-1.
  - pwm counter counts 0..15, advancing on sub-slot wrap.
  - row index counts 0..scan_limit, advancing on pwm wrap, then wraps to 0.
  - If scan_limit is written below the current row index, row index goes to 0 on the next clock.
- Outputs, registered, 1 clk after counters:
  - shutdown=1: row_n=8'hFF, col=0, counters keep running.
  - test=1 (overrides shutdown): all rows scanned, col=8'hFF, full brightness.
  - Otherwise: row_n has bit [row index] low. col=rows[row index] when pwm counter <= intensity, else 0. So intensity 15 gives 16/16 duty and intensity 0 gives 1/16.
- Simultaneous events:
  - Commit and scan advance in the same cycle: the new row data appears on col no later than 2 clks after wr_stb.
  - cs_n rising coincident with a synchronised sclk rise: the shift is processed first, then commit uses the updated bcount.
- Reset mid-frame: the partial frame is discarded and all state returns to reset values. A frame in progress after rst deassert is only received if cs_n falls again.

Test Plan:
- After rst: send frame 0x0C01 (shutdown off), then 0x0B07 and 0x0A0F. Send 0x0100..0x0800 pattern rows 0x01,0x02,..0x80 -> each frame gives wr_stb with matching addr/data. Each row slot shows row_n=~(1<<i), col=1<<i for the full 16*PWM_DIV cycles.
- Intensity 0x0A03, rows[0]=0xFF, scan_limit 0 -> col=0xFF for exactly 4*PWM_DIV of every 16*PWM_DIV cycles, row_n=8'hFE constant.
- Short frame of 12 bits then cs_n high -> frame_err pulse, bcount=12, no wr_stb, registers unchanged.
- 20-bit frame whose last 16 bits are 0x0355 -> commit addr=3, data=0x55, bcount=16.
- 0x0F01 while shutdown=1 -> col=0xFF on all rows. Then 0x0F00 -> row_n=8'hFF, col=0.
- Assert rst for 1 cycle after 8 bits of a frame -> bcount=0, row_n=8'hFF. Remaining 8 bits with cs_n rising -> frame_err only if cs_n fell after reset, otherwise nothing.
